// File: rtl/rng_pkg.sv
// ----------------------------------------------------------------------------
// rng_pkg: shared types, constants and mask helper for rng_range_buffer. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rng_pkg;

  localparam int RNG_WORD_W = 16;

  typedef enum logic [1:0] {
    LO   = 2'd0,
    HI   = 2'd1,
    EVAL = 2'd2
  } rng_state_t;

  // Smear the highest set bit downward: gives the smallest 2^k-1 covering range_max.
  function automatic logic [RNG_WORD_W-1:0] mask_for(input logic [RNG_WORD_W-1:0] range_max);
    logic [RNG_WORD_W-1:0] m;
    m = range_max;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rng_fifo.sv
// ----------------------------------------------------------------------------
// rng_fifo: show-ahead synchronous FIFO with flush and registered flags. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rng_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot on the same edge, so a push into a full FIFO is legal then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      full  <= (count_next == DEPTH_C);
      empty <= (count_next == '0);
    end
  end

endmodule

`default_nettype wire

// File: rtl/rng_range_buffer.sv
// ----------------------------------------------------------------------------
// rng_range_buffer: packs LFSR bytes, mask-and-reject ranges them, buffers results. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rng_range_buffer
  import rng_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WORD_W = RNG_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        lfsr_q,
  input  logic              lfsr_vld,
  input  logic [WORD_W-1:0] range_max,
  input  logic              flush,
  input  logic              rd_en,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_vld,
  output logic              full,
  output logic [WORD_W-1:0] reject_cnt
);

  localparam int               CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  rng_state_t        state;
  logic [7:0]        lo_byte;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] mask;
  logic [WORD_W-1:0] cand;
  logic              in_range;
  logic              pop_ok;
  logic              can_push;
  logic              push;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  assign mask     = mask_for(range_max);
  assign cand     = word & mask;
  assign in_range = (cand <= range_max);
  assign rd_vld   = !fifo_empty;
  assign pop_ok   = rd_en && rd_vld;
  assign can_push = (fifo_count != DEPTH_C) || pop_ok;
  assign push     = (state == EVAL) && in_range && can_push && !flush;

  rng_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (cand),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .count     (fifo_count),
    .full      (full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LO;
      lo_byte    <= '0;
      word       <= '0;
      reject_cnt <= '0;
    end else if (flush) begin
      state <= LO;
    end else begin
      case (state)
        LO: begin
          if (lfsr_vld) begin
            lo_byte <= lfsr_q;
            state   <= HI;
          end
        end
        HI: begin
          if (lfsr_vld) begin
            word  <= {lfsr_q, lo_byte};
            state <= EVAL;
          end
        end
        EVAL: begin
          // Out-of-range candidates are discarded; in-range ones wait for a slot.
          if (!in_range) begin
            if (reject_cnt != '1) reject_cnt <= reject_cnt + WORD_W'(1);
            state <= LO;
          end else if (can_push) begin
            state <= LO;
          end
        end
        default: state <= LO;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rng_range_buffer.sv
// ----------------------------------------------------------------------------
// tb_rng_range_buffer: directed and randomized self-checking bench. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_rng_range_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  lfsr_q;
  logic        lfsr_vld;
  logic [15:0] range_max;
  logic        flush;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rd_vld;
  logic        full;
  logic [15:0] reject_cnt;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_rej  = 0;
  logic [15:0] q[$];

  rng_range_buffer #(.DEPTH(DEPTH), .WORD_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .lfsr_q     (lfsr_q),
    .lfsr_vld   (lfsr_vld),
    .range_max  (range_max),
    .flush      (flush),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_vld     (rd_vld),
    .full       (full),
    .reject_cnt (reject_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    lfsr_q   = b;
    lfsr_vld = 1'b1;
    tick();
    lfsr_vld = 1'b0;
    lfsr_q   = 8'($urandom);
  endtask

  // Two bytes then the evaluation cycle.
  task automatic send_word(input logic [15:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    tick();
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  function automatic int model_mask(input int rm);
    int m = 0;
    while (m < rm) m = (m << 1) | 1;
    return m;
  endfunction

  task automatic model_word(input logic [15:0] w, input logic [15:0] rm);
    int c;
    c = int'(w) & model_mask(int'(rm));
    if (c <= int'(rm)) q.push_back(16'(c));
    else if (exp_rej < 65535) exp_rej++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (rd_data !== 16'h0)    $display("FAIL rst_data: got %h want 0000", rd_data); else n_pass++;
    n_checks++; if (rd_vld !== 1'b0)      $display("FAIL rst_vld: got %b want 0", rd_vld); else n_pass++;
    n_checks++; if (full !== 1'b0)        $display("FAIL rst_full: got %b want 0", full); else n_pass++;
    n_checks++; if (reject_cnt !== 16'h0) $display("FAIL rst_rej: got %h want 0000", reject_cnt); else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++; if (rd_vld !== 1'b0) $display("FAIL rst_idle_vld: got %b want 0", rd_vld); else n_pass++;
  endtask

  task automatic test_latency();
    range_max = 16'hFFFF;
    send_byte(8'h12);
    send_byte(8'h34);
    n_checks++; if (rd_vld !== 1'b0) $display("FAIL lat_early: got vld=%b want 0", rd_vld); else n_pass++;
    tick();
    n_checks++; if (rd_vld !== 1'b1)        $display("FAIL lat_vld: got %b want 1", rd_vld); else n_pass++;
    n_checks++; if (rd_data !== 16'h3412)   $display("FAIL lat_data: got %h want 3412", rd_data); else n_pass++;
    n_checks++; if (reject_cnt !== 16'h0)   $display("FAIL lat_rej: got %h want 0000", reject_cnt); else n_pass++;
    pop1();
    n_checks++; if (rd_vld !== 1'b0) $display("FAIL lat_pop: got vld=%b want 0", rd_vld); else n_pass++;
  endtask

  task automatic test_reject();
    range_max = 16'd9;
    send_word(16'h000C);
    model_word(16'h000C, 16'd9);
    send_word(16'h5007);
    model_word(16'h5007, 16'd9);
    n_checks++; if (reject_cnt !== 16'(exp_rej)) $display("FAIL rej_cnt: got %0d want %0d", reject_cnt, exp_rej); else n_pass++;
    n_checks++; if (rd_vld !== 1'b1 || rd_data !== q[0])
      $display("FAIL rej_data: got vld=%b data=%h want vld=1 data=%h", rd_vld, rd_data, q[0]); else n_pass++;
    void'(q.pop_front());
    pop1();
    n_checks++; if (rd_vld !== 1'b0) $display("FAIL rej_empty: got vld=%b want 0", rd_vld); else n_pass++;
  endtask

  task automatic test_full_stall();
    logic [15:0] w [6];
    range_max = 16'hFFFF;
    for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) send_word(w[i]);
    n_checks++; if (full !== 1'b1) $display("FAIL full_set: got %b want 1", full); else n_pass++;
    send_word(w[4]);
    send_byte(8'hA5);
    send_byte(8'h5A);
    n_checks++; if (full !== 1'b1 || rd_data !== w[0])
      $display("FAIL stall_hold: got full=%b data=%h want full=1 data=%h", full, rd_data, w[0]); else n_pass++;
    pop1();
    n_checks++; if (full !== 1'b1 || rd_data !== w[1])
      $display("FAIL stall_pushpop: got full=%b data=%h want full=1 data=%h", full, rd_data, w[1]); else n_pass++;
    for (int i = 1; i < 5; i++) begin
      n_checks++; if (rd_vld !== 1'b1 || rd_data !== w[i])
        $display("FAIL stall_drain%0d: got vld=%b data=%h want vld=1 data=%h", i, rd_vld, rd_data, w[i]); else n_pass++;
      pop1();
    end
    n_checks++; if (rd_vld !== 1'b0 || full !== 1'b0)
      $display("FAIL stall_empty: got vld=%b full=%b want 0 0", rd_vld, full); else n_pass++;
    send_word(w[5]);
    n_checks++; if (rd_data !== w[5]) $display("FAIL stall_resync: got %h want %h", rd_data, w[5]); else n_pass++;
    pop1();
  endtask

  task automatic test_pop_empty();
    logic [15:0] a, b;
    a = 16'($urandom);
    b = 16'($urandom);
    range_max = 16'hFFFF;
    pop1();
    n_checks++; if (rd_vld !== 1'b0 || full !== 1'b0)
      $display("FAIL underflow: got vld=%b full=%b want 0 0", rd_vld, full); else n_pass++;
    send_word(a);
    n_checks++; if (rd_vld !== 1'b1 || rd_data !== a)
      $display("FAIL after_underflow: got vld=%b data=%h want vld=1 data=%h", rd_vld, rd_data, a); else n_pass++;
    send_byte(b[7:0]);
    send_byte(b[15:8]);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++; if (rd_vld !== 1'b1 || rd_data !== b)
      $display("FAIL pushpop1: got vld=%b data=%h want vld=1 data=%h", rd_vld, rd_data, b); else n_pass++;
    pop1();
    n_checks++; if (rd_vld !== 1'b0) $display("FAIL pushpop1_empty: got vld=%b want 0", rd_vld); else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] rm, w;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0:       rm = 16'($urandom_range(0, 20));
        1:       rm = 16'((1 << $urandom_range(0, 15)) - $urandom_range(0, 1));
        2:       rm = 16'($urandom);
        default: rm = 16'hFFFF;
      endcase
      range_max = rm;
      w = 16'($urandom);
      for (int b = 0; b < 2; b++) begin
        repeat ($urandom_range(0, 2)) begin
          lfsr_q = 8'($urandom);
          tick();
        end
        send_byte(b == 0 ? w[7:0] : w[15:8]);
      end
      tick();
      model_word(w, rm);
      n_checks++; if (reject_cnt !== 16'(exp_rej))
        $display("FAIL rnd_rej it%0d: got %0d want %0d", it, reject_cnt, exp_rej); else n_pass++;
      if (q.size() >= DEPTH - 1 || $urandom_range(0, 3) == 0) begin
        while (q.size() > 0) begin
          n_checks++; if (rd_vld !== 1'b1 || rd_data !== q[0])
            $display("FAIL rnd_pop it%0d: got vld=%b data=%h want vld=1 data=%h", it, rd_vld, rd_data, q[0]); else n_pass++;
          void'(q.pop_front());
          pop1();
        end
      end
    end
    while (q.size() > 0) begin
      n_checks++; if (rd_vld !== 1'b1 || rd_data !== q[0])
        $display("FAIL rnd_tail: got vld=%b data=%h want vld=1 data=%h", rd_vld, rd_data, q[0]); else n_pass++;
      void'(q.pop_front());
      pop1();
    end
    n_checks++; if (rd_vld !== 1'b0) $display("FAIL rnd_empty: got vld=%b want 0", rd_vld); else n_pass++;
  endtask

  task automatic test_flush();
    logic [15:0] c;
    c = 16'($urandom);
    range_max = 16'hFFFF;
    for (int i = 0; i < 3; i++) send_word(16'($urandom));
    send_byte(8'($urandom));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (rd_vld !== 1'b0 || full !== 1'b0)
      $display("FAIL flush_empty: got vld=%b full=%b want 0 0", rd_vld, full); else n_pass++;
    n_checks++; if (reject_cnt !== 16'(exp_rej))
      $display("FAIL flush_rej: got %0d want %0d", reject_cnt, exp_rej); else n_pass++;
    send_word(c);
    n_checks++; if (rd_vld !== 1'b1 || rd_data !== c)
      $display("FAIL flush_fresh: got vld=%b data=%h want vld=1 data=%h", rd_vld, rd_data, c); else n_pass++;
    pop1();
  endtask

  task automatic test_async_reset();
    range_max = 16'hFFFF;
    for (int i = 0; i < 5; i++) send_word(16'($urandom) | 16'h0101);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (rd_data !== 16'h0 || rd_vld !== 1'b0 || full !== 1'b0 || reject_cnt !== 16'h0)
      $display("FAIL async_rst: got data=%h vld=%b full=%b rej=%h want all 0", rd_data, rd_vld, full, reject_cnt); else n_pass++;
    exp_rej = 0;
    #1;
    rst = 1'b0;
    tick();
    range_max = 16'h0;
    for (int i = 0; i < 4; i++) begin
      send_word(16'($urandom));
      n_checks++; if (rd_vld !== 1'b1 || rd_data !== 16'h0)
        $display("FAIL zero_range%0d: got vld=%b data=%h want vld=1 data=0000", i, rd_vld, rd_data); else n_pass++;
      pop1();
    end
    n_checks++; if (reject_cnt !== 16'h0 || rd_vld !== 1'b0)
      $display("FAIL zero_range_end: got rej=%h vld=%b want 0000 0", reject_cnt, rd_vld); else n_pass++;
  endtask

  initial begin
    rst       = 1'b1;
    lfsr_q    = 8'h0;
    lfsr_vld  = 1'b0;
    range_max = 16'hFFFF;
    flush     = 1'b0;
    rd_en     = 1'b0;
    test_reset();
    test_latency();
    test_reject();
    test_full_stall();
    test_pop_empty();
    test_random();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
